// File: rtl/data_inf_pack_pkg.sv
// ---------------------------------------------------------------------------
// data_inf_pack_pkg
// Shared types and helpers for the byte-to-word packer.
//   pack_state_e : FILL (accepting bytes) / STALL (holding a finished word)
//   CNT_W        : lane counter width, sized for the largest legal RATIO (8)
//   lane_idx()   : maps beat number within a word to its output lane
// Optional build macro: DATA_INF_PACK_MSB_FIRST_EN (beat 0 lands in the top
// lane instead of lane 0).
// ---------------------------------------------------------------------------
package data_inf_pack_pkg;

  typedef enum logic {FILL = 1'b0, STALL = 1'b1} pack_state_e;

  // RATIO is a module parameter limited to 2..8, so one counter width
  // covering the maximum serves every legal instance.
  localparam int MAX_RATIO = 8;
  localparam int CNT_W     = $clog2(MAX_RATIO);

  // Lane that beat number cnt occupies within a word of ratio lanes.
  function automatic logic [CNT_W-1:0] lane_idx(input logic [CNT_W-1:0] cnt,
                                                input int               ratio);
`ifdef DATA_INF_PACK_MSB_FIRST_EN
    lane_idx = CNT_W'(ratio - 1 - int'(cnt));
`else
    // cnt never reaches ratio, so this is a plain pass-through.
    if (int'(cnt) < ratio) begin
      lane_idx = cnt;
    end else begin
      lane_idx = {CNT_W{1'b0}};
    end
`endif
  endfunction

endpackage

// File: rtl/data_inf_pack_8to32.sv
// ---------------------------------------------------------------------------
// data_inf_pack_8to32
// Packs RATIO consecutive ISIZE-bit beats into one ISIZE*RATIO-bit word with
// a per-lane keep mask. A word closes when all lanes are filled or when the
// packet's last beat arrives. Sustains one input beat per cycle as long as
// the downstream keeps up; a one-word skid (the assembly register) absorbs
// a stalled output before in_ready drops.
// Optional build macro: DATA_INF_PACK_MSB_FIRST_EN (reverse lane order).
//
// Ports:
//   clock     in   clock, posedge active
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   input beat valid
//   in_ready  out  input beat accepted when in_valid && in_ready (registered)
//   in_data   in   input beat, ISIZE bits
//   in_last   in   final beat of packet
//   out_valid out  output word valid
//   out_ready in   downstream accept
//   out_data  out  packed word, ISIZE*RATIO bits
//   out_keep  out  lane-valid mask, RATIO bits
//   out_last  out  word holds the packet's final beat
// ---------------------------------------------------------------------------
module data_inf_pack_8to32
  import data_inf_pack_pkg::*;
#(
  parameter int ISIZE = 8,
  parameter int RATIO = 4
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ISIZE-1:0]       in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ISIZE*RATIO-1:0] out_data,
  output logic [RATIO-1:0]       out_keep,
  output logic                   out_last
);

  localparam int OSIZE = ISIZE * RATIO;

  pack_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [OSIZE-1:0] asm_data;
  logic [RATIO-1:0] asm_keep;
  logic             asm_last;

  logic [CNT_W-1:0] lane;
  logic [OSIZE-1:0] word_data;
  logic [RATIO-1:0] word_keep;
  logic             accept;
  logic             out_free;
  logic             complete;

  // Assembly word with the current beat merged in, plus handshake decodes.
  always_comb begin
    lane      = lane_idx(cnt, RATIO);
    accept    = in_valid && in_ready;
    out_free  = !out_valid || out_ready;
    complete  = accept && ((cnt == CNT_W'(RATIO - 1)) || in_last);
    word_data = asm_data;
    word_data[lane*ISIZE +: ISIZE] = in_data;
    word_keep = asm_keep | ({{(RATIO-1){1'b0}}, 1'b1} << lane);
  end

  // Packer state machine with registered output stage and registered in_ready.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      in_ready  <= 1'b1;
      cnt       <= {CNT_W{1'b0}};
      asm_data  <= {OSIZE{1'b0}};
      asm_keep  <= {RATIO{1'b0}};
      asm_last  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= {OSIZE{1'b0}};
      out_keep  <= {RATIO{1'b0}};
      out_last  <= 1'b0;
    end else begin
      // An accepted output word retires unless a new word replaces it below.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        FILL: begin
          if (accept) begin
            if (complete) begin
              cnt <= {CNT_W{1'b0}};
              if (out_free) begin
                // Direct transfer: no bubble even when the old word leaves now.
                out_valid <= 1'b1;
                out_data  <= word_data;
                out_keep  <= word_keep;
                out_last  <= in_last;
                asm_data  <= {OSIZE{1'b0}};
                asm_keep  <= {RATIO{1'b0}};
                asm_last  <= 1'b0;
              end else begin
                // Output occupied: park the finished word and stop input.
                asm_data <= word_data;
                asm_keep <= word_keep;
                asm_last <= in_last;
                state    <= STALL;
                in_ready <= 1'b0;
              end
            end else begin
              asm_data <= word_data;
              asm_keep <= word_keep;
              cnt      <= cnt + CNT_W'(1);
            end
          end
        end
        STALL: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b1;
            out_data  <= asm_data;
            out_keep  <= asm_keep;
            out_last  <= asm_last;
            asm_data  <= {OSIZE{1'b0}};
            asm_keep  <= {RATIO{1'b0}};
            asm_last  <= 1'b0;
            state     <= FILL;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= FILL;
          in_ready <= 1'b1;
          cnt      <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_inf_pack_8to32.sv
module tb_data_inf_pack_8to32;

  localparam int ISIZE = 8;
  localparam int RATIO = 4;
  localparam int OSIZE = ISIZE * RATIO;

  typedef struct packed {
    logic [OSIZE-1:0] data;
    logic [RATIO-1:0] keep;
    logic             last;
  } word_t;

  logic             clock;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [ISIZE-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OSIZE-1:0] out_data;
  logic [RATIO-1:0] out_keep;
  logic             out_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ISIZE-1:0] tx_data[$];
  logic             tx_last[$];
  word_t            exp_q[$];
  word_t            got_q[$];

  data_inf_pack_8to32 #(.ISIZE(ISIZE), .RATIO(RATIO)) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_keep (out_keep),
    .out_last (out_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: chop the byte stream into packets, each packet into
  // groups of RATIO bytes, and place byte k of a group in its lane.
  function automatic void build_expected();
    word_t w;
    int    k;
    int    ln;
    exp_q.delete();
    w = '0;
    k = 0;
    for (int i = 0; i < tx_data.size(); i++) begin
`ifdef DATA_INF_PACK_MSB_FIRST_EN
      ln = RATIO - 1 - k;
`else
      ln = k;
`endif
      w.data = w.data | (OSIZE'(tx_data[i]) << (ln * ISIZE));
      w.keep = w.keep | (RATIO'(1) << ln);
      k++;
      if (k == RATIO || tx_last[i]) begin
        w.last = tx_last[i];
        exp_q.push_back(w);
        w = '0;
        k = 0;
      end
    end
  endfunction

  // Stream tx_data through the DUT, collecting every accepted output word.
  task automatic run_traffic(input bit rand_bubbles, input bit rand_ready,
                             output bit saw_stall);
    int    sent = 0;
    int    cyc  = 0;
    word_t w;
    saw_stall = 1'b0;
    got_q.delete();
    while ((sent < tx_data.size() || got_q.size() < exp_q.size()) && cyc < 2000) begin
      @(negedge clock);
      cyc++;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        w.data = out_data;
        w.keep = out_keep;
        w.last = out_last;
        got_q.push_back(w);
      end
      if (sent < tx_data.size() && (!rand_bubbles || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_data  = tx_data[sent];
        in_last  = tx_last[sent];
        if (in_ready) sent++;
        else saw_stall = 1'b1;
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'b0;
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (cyc >= 2000) begin
      n_fail++;
      $display("FAIL traffic_timeout: sent %0d of %0d beats, got %0d of %0d words",
               sent, tx_data.size(), got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({out_valid, out_data, out_keep, out_last, in_ready} !== {1'b0, 32'h0, 4'h0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b data=%h keep=%h last=%b in_ready=%b, expected 0/0/0/0/1",
               out_valid, out_data, out_keep, out_last, in_ready);
    end
  endtask

  task automatic test_stream();
    bit stall;
    logic [OSIZE-1:0] lit0, lit1;
    tx_data.delete(); tx_last.delete();
    for (int i = 1; i <= 8; i++) begin
      tx_data.push_back(8'(i * 8'h11));
      tx_last.push_back(i == 8);
    end
    build_expected();
    run_traffic(1'b0, 1'b0, stall);
`ifdef DATA_INF_PACK_MSB_FIRST_EN
    lit0 = 32'h11223344; lit1 = 32'h55667788;
`else
    lit0 = 32'h44332211; lit1 = 32'h88776655;
`endif
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_in_ready: in_ready dropped while streaming, expected constant 1");
    end
    n_checks++;
    if (got_q.size() !== 2) begin
      n_fail++;
      $display("FAIL stream_count: got %0d words, expected 2", got_q.size());
    end else begin
      n_checks++;
      if (got_q[0] !== word_t'({lit0, 4'hF, 1'b0})) begin
        n_fail++;
        $display("FAIL stream_word0: got %h/%h/%b, expected %h/f/0",
                 got_q[0].data, got_q[0].keep, got_q[0].last, lit0);
      end
      n_checks++;
      if (got_q[1] !== word_t'({lit1, 4'hF, 1'b1})) begin
        n_fail++;
        $display("FAIL stream_word1: got %h/%h/%b, expected %h/f/1",
                 got_q[1].data, got_q[1].keep, got_q[1].last, lit1);
      end
    end
  endtask

  task automatic test_partial();
    bit stall;
    tx_data.delete(); tx_last.delete();
    tx_data = '{8'hA1, 8'hA2, 8'hA3, 8'h5C};
    tx_last = '{1'b0, 1'b0, 1'b1, 1'b1};
    build_expected();
    run_traffic(1'b0, 1'b0, stall);
    n_checks++;
    if (got_q.size() !== 2) begin
      n_fail++;
      $display("FAIL partial_count: got %0d words, expected 2", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL partial_word%0d: got %h/%h/%b, expected %h/%h/%b", i,
                   got_q[i].data, got_q[i].keep, got_q[i].last,
                   exp_q[i].data, exp_q[i].keep, exp_q[i].last);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int    idx = 0;
    int    cyc = 0;
    word_t w;
    tx_data.delete(); tx_last.delete();
    for (int i = 0; i < 8; i++) begin
      tx_data.push_back(8'($urandom));
      tx_last.push_back(i == 7);
    end
    build_expected();
    got_q.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      out_ready = 1'b0;
      if (out_valid) begin
        n_checks++;
        if (out_data !== exp_q[0].data || out_keep !== exp_q[0].keep || out_last !== exp_q[0].last) begin
          n_fail++;
          $display("FAIL hold_stable: cycle %0d out %h/%h/%b, expected %h/%h/%b", c,
                   out_data, out_keep, out_last, exp_q[0].data, exp_q[0].keep, exp_q[0].last);
        end
      end
      if (idx < 8) begin
        in_valid = 1'b1; in_data = tx_data[idx]; in_last = tx_last[idx];
        if (in_ready) idx++;
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
    end
    n_checks++;
    if ({in_ready, out_valid} !== 2'b01 || idx !== 8) begin
      n_fail++;
      $display("FAIL stall_state: in_ready=%b out_valid=%b beats=%0d, expected 0/1/8",
               in_ready, out_valid, idx);
    end
    in_valid = 1'b0;
    while (got_q.size() < 2 && cyc < 20) begin
      @(negedge clock);
      cyc++;
      out_ready = 1'b1;
      if (out_valid) begin
        w.data = out_data; w.keep = out_keep; w.last = out_last;
        got_q.push_back(w);
      end
    end
    n_checks++;
    if (got_q.size() !== 2) begin
      n_fail++;
      $display("FAIL drain_count: got %0d words, expected 2", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL drain_word%0d: got %h/%h/%b, expected %h/%h/%b", i,
                   got_q[i].data, got_q[i].keep, got_q[i].last,
                   exp_q[i].data, exp_q[i].keep, exp_q[i].last);
        end
      end
    end
    @(negedge clock);
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL drain_idle: out_valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    bit stall;
    logic [OSIZE-1:0] lit;
    while (idx < 6) begin
      @(negedge clock);
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'(8'hE0 + idx); in_last = 1'b0;
      if (in_ready) idx++;
    end
    @(negedge clock);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_valid: out_valid=%b, expected 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_data, out_keep, out_last} !== {1'b0, 32'h0, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b data=%h keep=%h last=%b, expected all 0",
               out_valid, out_data, out_keep, out_last);
    end
    @(negedge clock);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tx_data.delete(); tx_last.delete();
    tx_data = '{8'h01, 8'h02, 8'h03, 8'h04};
    tx_last = '{1'b0, 1'b0, 1'b0, 1'b0};
    build_expected();
    run_traffic(1'b0, 1'b0, stall);
`ifdef DATA_INF_PACK_MSB_FIRST_EN
    lit = 32'h01020304;
`else
    lit = 32'h04030201;
`endif
    n_checks++;
    if (got_q.size() !== 1 || got_q[0] !== word_t'({lit, 4'hF, 1'b0})) begin
      n_fail++;
      $display("FAIL post_reset_word: got %0d words first=%h, expected 1 word %h/f/0",
               got_q.size(), (got_q.size() > 0) ? got_q[0].data : 32'h0, lit);
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: out_valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_random();
    bit stall;
    for (int round = 0; round < 6; round++) begin
      tx_data.delete(); tx_last.delete();
      for (int p = 0; p < 5; p++) begin
        int len = $urandom_range(1, 11);
        for (int b = 0; b < len; b++) begin
          tx_data.push_back(8'($urandom));
          tx_last.push_back(b == len - 1);
        end
      end
      build_expected();
      run_traffic(1'b1, 1'b1, stall);
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin
        n_fail++;
        $display("FAIL random_count: round %0d got %0d words, expected %0d",
                 round, got_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_checks++;
          if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL random_word: round %0d word %0d got %h/%h/%b, expected %h/%h/%b",
                     round, i, got_q[i].data, got_q[i].keep, got_q[i].last,
                     exp_q[i].data, exp_q[i].keep, exp_q[i].last);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_partial();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
